fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
- Pipelined floating-point compare execution stage in the FPU path.
- Accepts an issued compare micro-op (feq/flt/fle) with two IEEE-754 single-precision operands and a destination tag.
- Uses the existing combinational flt less-than block for ordering. Adds equality, NaN screening and invalid-flag generation.
- Returns a 32-bit integer result (0 or 1) plus tag to integer writeback over a valid/ready handshake.

Parameters:
- TAG_W, 5, width of destination register tag carried alongside the operation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all in-flight ops (branch mispredict)
- in_valid  in  1  issue side has an op
- in_ready  out  1  stage can accept an op this cycle
- in_op  in  2  00 feq, 01 flt, 10 fle, 11 reserved
- in_x1  in  32  operand 1 (IEEE single)
- in_x2  in  32  operand 2 (IEEE single)
- in_rd  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_data  out  32  result, bit0 = compare outcome, bits31:1 = 0
- out_rd  out  TAG_W  destination tag of result
- out_nv  out  1  invalid-operation flag for fflags

Behaviour:
- Reset: asynchronous, active-high. Both stage valid bits, out_valid, out_data, out_rd and out_nv go to 0 immediately and stay 0 while rst=1. Reset mid-operation discards all in-flight ops.
- Two register stages, S1 and S2.
- S1 captures op, x1, x2 and rd. Combinationally from S1 it decodes:
  - qNaN: exp=FF, m!=0, m[22]=1.
  - sNaN: exp=FF, m!=0, m[22]=0.
  - zero: exp=0, m=0.
- S2 holds the final result. out_* are driven directly from S2 registers.
- Latency: exactly 2 cycles from the accept edge (in_valid && in_ready) to out_valid=1, assuming no stall.
- Throughput: 1 op per cycle.
- Advance rules:
  - s2_en = !s2_valid || out_ready.
  - s1 advances into S2 when s2_en.
  - in_ready = !s1_valid || s2_en, combinational, with no dependence on in_valid.
  - On a cycle with neither accept nor advance, S1 keeps its value. When S1 advances without a new accept, s1_valid clears.
- Stall: while out_valid && !out_ready, out_data, out_rd and out_nv hold stable. S1 keeps its contents, and in_ready is 0 once S1 is also full.
- Result computation, with lt = flt(x1, x2):
  - eq = (x1 == x2) || (both zero).
  - feq = eq; flt = lt; fle = lt || eq.
  - If either operand is NaN, result = 0 for every op.
- Zero handling: +0 and -0 compare equal. flt(-0, +0) = 0; fle(-0, +0) = 1. Denormals are ordered by magnitude, as in flt.
- Invalid flag:
  - out_nv = 1 for flt/fle when any operand is NaN (qNaN or sNaN).
  - out_nv = 1 for feq only when any operand is sNaN.
  - out_nv = 0 otherwise.
- Reserved op 11: result 0, out_nv 0. It still flows through the pipe and produces out_valid.
- Flush: at the next edge s1_valid and s2_valid clear and out_valid drops. An accept in the flush cycle is discarded. Flush has priority over all advances.
- Simultaneous accept and S1→S2 advance in the same cycle: the new op enters S1 and the old S1 op enters S2. No bubble, no loss.
- Ops leave in accept order. Ops are never duplicated or dropped except by flush or reset.

Test Plan:
- Back-to-back, out_ready=1:
  - flt(0x3F800000, 0x40000000) then flt(0x40000000, 0x3F800000) → out_data 1 then 0, on cycles 2 and 3 after first accept, out_nv=0.
- Signed zero and negatives:
  - feq(0x80000000, 0x00000000) → 1.
  - flt(0x80000000, 0x00000000) → 0.
  - fle same operands → 1.
  - flt(0xC0000000, 0xBF800000) → 1 (-2 < -1).
- NaN:
  - feq(0x7FC00000, 0x3F800000) → 0, nv=0.
  - feq(0x7F800001, 0x3F800000) → 0, nv=1.
  - fle(0x7FC00000, 0x7FC00000) → 0, nv=1.
- Backpressure:
  - Hold out_ready=0 and issue 3 ops with rd=1,2,3 → in_ready drops after the 2nd accept, and out_* stay stable on rd=1.
  - Release out_ready → results arrive in order rd=1,2,3.
- Flush with both stages full and an accept in the same cycle → next cycle out_valid=0, in_ready=1. No result ever appears for the 3 killed ops.
- Assert rst asynchronously mid-stream with out_valid=1 → out_valid, out_data and out_nv go to 0 before the next clock edge. The op after reset release returns a correct result with 2-cycle latency.

Source files
------------

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined single-precision compare (feq/flt/fle) for the FPU path.
// Integer result and invalid flag go to integer writeback over valid/ready.

// Combinational IEEE single less-than. NaN operands are screened by the caller.
module fcmp_lt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);
    logic a_zero;
    logic b_zero;

    assign a_zero = (a[30:0] == 31'd0);
    assign b_zero = (b[30:0] == 31'd0);

    // Sign-magnitude ordering; +0 and -0 are never less than each other
    always_comb begin
        lt = 1'b0;
        if (!(a_zero && b_zero)) begin
            if (a[31] != b[31])
                lt = a[31];
            else if (!a[31])
                lt = (a[30:0] < b[30:0]);
            else
                lt = (a[30:0] > b[30:0]);
        end
    end
endmodule

module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_nv
);
    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [31:0]      s1_x1;
    logic [31:0]      s1_x2;
    logic [TAG_W-1:0] s1_rd;

    logic             s2_valid;
    logic             s2_res;
    logic [TAG_W-1:0] s2_rd;
    logic             s2_nv;

    logic s2_en;
    logic accept;

    logic x1_nan, x2_nan, x1_snan, x2_snan, x1_zero, x2_zero;
    logic any_nan, any_snan;
    logic lt, eq;
    logic res_c, nv_c;

    assign s2_en    = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_en;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;
    assign out_data  = {{31{1'b0}}, s2_res};
    assign out_rd    = s2_rd;
    assign out_nv    = s2_nv;

    // Operand classification from the S1 registers
    always_comb begin
        x1_nan  = (s1_x1[30:23] == 8'hFF) && (s1_x1[22:0] != 23'd0);
        x2_nan  = (s1_x2[30:23] == 8'hFF) && (s1_x2[22:0] != 23'd0);
        x1_snan = x1_nan && !s1_x1[22];
        x2_snan = x2_nan && !s1_x2[22];
        x1_zero = (s1_x1[30:0] == 31'd0);
        x2_zero = (s1_x2[30:0] == 31'd0);
        any_nan  = x1_nan || x2_nan;
        any_snan = x1_snan || x2_snan;
    end

    fcmp_lt u_lt (
        .a  (s1_x1),
        .b  (s1_x2),
        .lt (lt)
    );

    // Result and invalid-flag selection per op, with NaN forcing result 0
    always_comb begin
        eq    = (s1_x1 == s1_x2) || (x1_zero && x2_zero);
        res_c = 1'b0;
        nv_c  = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                res_c = eq && !any_nan;
                nv_c  = any_snan;
            end
            OP_FLT: begin
                res_c = lt && !any_nan;
                nv_c  = any_nan;
            end
            OP_FLE: begin
                res_c = (lt || eq) && !any_nan;
                nv_c  = any_nan;
            end
            default: begin
                res_c = 1'b0;
                nv_c  = 1'b0;
            end
        endcase
    end

    // S1: capture on accept, drain when handed to S2, flush kills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_rd    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_x1    <= in_x1;
            s1_x2    <= in_x2;
            s1_rd    <= in_rd;
        end else if (s2_en) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: load the computed result when the output slot is free or consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= 1'b0;
            s2_rd    <= '0;
            s2_nv    <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= res_c;
                s2_rd  <= s1_rd;
                s2_nv  <= nv_c;
            end
        end
    end
endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: driver pushes hand-computed expectations,
// monitor pops and compares on every output handshake.
module tb_fcmp_pipe;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_rd;
    logic             out_nv;

    typedef struct {
        logic [TAG_W-1:0] rd;
        logic [31:0]      data;
        logic             nv;
        bit               chk_lat;
        int               acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_nv    (out_nv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare each consumed result against the head of the scoreboard
    always @(negedge clk) begin
        #2;
        if (!rst && !flush && out_valid && out_ready) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_out: got rd=%0d data=%h nv=%0b with empty scoreboard",
                         out_rd, out_data, out_nv);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_rd !== e.rd || out_data !== e.data || out_nv !== e.nv) begin
                    fails = fails + 1;
                    $display("FAIL result rd%0d: got rd=%0d data=%h nv=%0b expected rd=%0d data=%h nv=%0b",
                             e.rd, out_rd, out_data, out_nv, e.rd, e.data, e.nv);
                end
                if (e.chk_lat) begin
                    tests = tests + 1;
                    if (cyc - e.acc_cyc + 1 != 2) begin
                        fails = fails + 1;
                        $display("FAIL latency rd%0d: got %0d edges expected 2",
                                 e.rd, cyc - e.acc_cyc + 1);
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accept
    task automatic issue(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [TAG_W-1:0] rd, input logic [31:0] ed, input logic env,
                         input bit lat);
        exp_t e;
        bit   done;
        done = 0;
        in_valid = 1'b1;
        in_op = op;
        in_x1 = x1;
        in_x2 = x2;
        in_rd = rd;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                e.rd = rd; e.data = ed; e.nv = env; e.chk_lat = lat; e.acc_cyc = cyc + 1;
                exp_q.push_back(e);
                done = 1;
                @(negedge clk);
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL accept_timeout rd%0d: in_ready never 1 within 50 cycles", rd);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_x1 = '0; in_x2 = '0; in_rd = '0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with latency check
        issue(2'b01, 32'h3F800000, 32'h40000000, 5'd1, 32'd1, 1'b0, 1);
        issue(2'b01, 32'h40000000, 32'h3F800000, 5'd2, 32'd0, 1'b0, 1);
        // Signed zero, negatives, denormals, inf
        issue(2'b00, 32'h80000000, 32'h00000000, 5'd3, 32'd1, 1'b0, 0);
        issue(2'b01, 32'h80000000, 32'h00000000, 5'd4, 32'd0, 1'b0, 0);
        issue(2'b10, 32'h80000000, 32'h00000000, 5'd5, 32'd1, 1'b0, 0);
        issue(2'b01, 32'hC0000000, 32'hBF800000, 5'd6, 32'd1, 1'b0, 0);
        issue(2'b01, 32'h00000001, 32'h00000002, 5'd7, 32'd1, 1'b0, 0);
        issue(2'b00, 32'h3F800000, 32'h3F800000, 5'd8, 32'd1, 1'b0, 0);
        issue(2'b10, 32'h40000000, 32'h3F800000, 5'd9, 32'd0, 1'b0, 0);
        issue(2'b00, 32'h7F800000, 32'h7F800000, 5'd10, 32'd1, 1'b0, 0);
        // NaN screening and invalid flag, reserved op
        issue(2'b00, 32'h7FC00000, 32'h3F800000, 5'd11, 32'd0, 1'b0, 0);
        issue(2'b00, 32'h7F800001, 32'h3F800000, 5'd12, 32'd0, 1'b1, 0);
        issue(2'b10, 32'h7FC00000, 32'h7FC00000, 5'd13, 32'd0, 1'b1, 0);
        issue(2'b01, 32'h7FC00000, 32'h00000000, 5'd14, 32'd0, 1'b1, 0);
        issue(2'b11, 32'h3F800000, 32'h40000000, 5'd15, 32'd0, 1'b0, 0);
        idle(4);

        // Backpressure
        out_ready = 1'b0;
        issue(2'b01, 32'h3F800000, 32'h40000000, 5'd1, 32'd1, 1'b0, 0);
        issue(2'b10, 32'h40000000, 32'h3F800000, 5'd2, 32'd0, 1'b0, 0);
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_rd", {27'd0, out_rd}, 32'd1);
            check("bp_hold_data", out_data, 32'd1);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        issue(2'b00, 32'h3F800000, 32'h3F800000, 5'd3, 32'd1, 1'b0, 0);
        idle(5);
        check("bp_drained", exp_q.size(), 32'd0);

        // Flush with both stages full and a same-cycle accept
        out_ready = 1'b0;
        issue(2'b01, 32'h3F800000, 32'h40000000, 5'd20, 32'd1, 1'b0, 0);
        issue(2'b01, 32'h3F800000, 32'h40000000, 5'd21, 32'd1, 1'b0, 0);
        out_ready = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1; in_op = 2'b01; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_rd = 5'd22;
        #1;
        check("flush_accept_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        idle(5);

        // Asynchronous reset with a result on the output
        out_ready = 1'b0;
        issue(2'b01, 32'h3F800000, 32'h40000000, 5'd25, 32'd1, 1'b0, 0);
        @(negedge clk);
        #1;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_data", out_data, 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_rd", {27'd0, out_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        issue(2'b10, 32'hBF800000, 32'hBF800000, 5'd26, 32'd1, 1'b0, 1);
        idle(5);
        check("final_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
